// File: rtl/wrr_packet_arbiter.sv
// Weighted round-robin packet arbiter: locks one output port to a single input
// for a whole packet and rotates priority according to per-source packet credits.
module wrr_packet_arbiter #(
  parameter int unsigned S_DATA_COUNT = 2,
  parameter int unsigned WEIGHT_WIDTH = 4,
  localparam int unsigned T_ID___WIDTH = $clog2(S_DATA_COUNT)
) (
  input  logic                                     clk_i,
  input  logic                                     rst_in,
  input  logic [S_DATA_COUNT-1:0]                  req_i,
  input  logic [S_DATA_COUNT-1:0]                  last_i,
  input  logic                                     m_ready_i,
  input  logic [S_DATA_COUNT-1:0][WEIGHT_WIDTH-1:0] weight_i,
  output logic [T_ID___WIDTH-1:0]                  grant_o,
  output logic                                     grant_valid_o,
  output logic [T_ID___WIDTH-1:0]                  ptr_o
);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e                  state_q, state_d;
  logic [T_ID___WIDTH-1:0] grant_q, grant_d;
  logic [T_ID___WIDTH-1:0] ptr_q, ptr_d;
  logic [WEIGHT_WIDTH-1:0] cnt_q, cnt_d;

  logic [T_ID___WIDTH-1:0] sel;
  logic [T_ID___WIDTH:0]   idx;
  logic                    found;
  logic [T_ID___WIDTH-1:0] ptr_inc;
  logic [WEIGHT_WIDTH:0]   cnt_inc;
  logic [WEIGHT_WIDTH:0]   weight_eff;
  logic                    last_xfer;

  // First requester at or after the pointer, wrapping inside [0, S_DATA_COUNT).
  always_comb begin
    sel   = ptr_q;
    found = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < S_DATA_COUNT; i++) begin
      idx = {1'b0, ptr_q} + (T_ID___WIDTH+1)'(i);
      if (idx >= (T_ID___WIDTH+1)'(S_DATA_COUNT)) begin
        idx = idx - (T_ID___WIDTH+1)'(S_DATA_COUNT);
      end
      if (!found && req_i[idx[T_ID___WIDTH-1:0]]) begin
        found = 1'b1;
        sel   = idx[T_ID___WIDTH-1:0];
      end
    end
  end

  assign ptr_inc    = (grant_q == T_ID___WIDTH'(S_DATA_COUNT - 1)) ? '0 : grant_q + 1'b1;
  assign cnt_inc    = {1'b0, cnt_q} + (WEIGHT_WIDTH+1)'(1);
  assign weight_eff = (weight_i[grant_q] == '0) ? (WEIGHT_WIDTH+1)'(1)
                                                : {1'b0, weight_i[grant_q]};
  assign last_xfer  = req_i[grant_q] && m_ready_i && last_i[grant_q];

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          grant_d = sel;
          state_d = StBusy;
          // Pointer holder is not requesting: its remaining turn is forfeited.
          if (sel != ptr_q) begin
            ptr_d = sel;
            cnt_d = '0;
          end
        end
      end
      StBusy: begin
        if (last_xfer) begin
          state_d = StIdle;
          if (cnt_inc >= weight_eff) begin
            ptr_d = ptr_inc;
            cnt_d = '0;
          end else begin
            ptr_d = grant_q;
            cnt_d = cnt_inc[WEIGHT_WIDTH-1:0];
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= StIdle;
      grant_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign grant_o       = grant_q;
  assign grant_valid_o = (state_q == StBusy);
  assign ptr_o         = ptr_q;

endmodule

// File: doc/wrr_packet_arbiter.md
# wrr_packet_arbiter

Per-output packet arbiter for the stream crossbar. It picks which input stream owns one output port using weighted round-robin. It holds that grant for a whole packet, from the first beat through the beat carrying `last`. One instance sits in front of each master port and drives the grant index consumed by the data connection net. Per-source weights are runtime inputs, so software can bias bandwidth between inputs without re-synthesis.

## Interface
- `S_DATA_COUNT`, default 2: number of input streams competing for this output. Must be ≥ 2.
- `WEIGHT_WIDTH`, default 4: width of each per-source weight.
- `T_ID___WIDTH`, localparam, $clog2(S_DATA_COUNT): width of the grant index.
- `clk_i`, in, 1: single clock; all state changes on its rising edge.
- `rst_in`, in, 1: asynchronous, active-low reset.
- `req_i`, in, S_DATA_COUNT: per source, valid AND dest equals this output.
- `last_i`, in, S_DATA_COUNT: per-source `last` flag of the current beat.
- `m_ready_i`, in, 1: ready of the output port served by this arbiter.
- `weight_i`, in, WEIGHT_WIDTH × [S_DATA_COUNT-1:0]: number of consecutive packets each source may send per turn. A weight of 0 is treated as 1.
- `grant_o`, out, T_ID___WIDTH: index of the source owning the output.
- `grant_valid_o`, out, 1: `grant_o` is valid and the output is locked to that source.
- `ptr_o`, out, T_ID___WIDTH: current round-robin priority pointer (debug/status).

## Operation
- State machine with two states: IDLE and BUSY. Registers:
  - `state`
  - `grant_o`
  - `ptr` (priority pointer)
  - `cnt` (packets sent by the `ptr` holder in its current turn, WEIGHT_WIDTH bits)
- IDLE:
  - If `req_i == 0`: stay in IDLE; all registers hold.
  - Otherwise, select `sel` = first set bit of `req_i`, searching `ptr`, `ptr+1`, … with wrap modulo S_DATA_COUNT.
  - Next edge: `grant_o <= sel`, `grant_valid_o <= 1`, go to BUSY.
  - If `sel != ptr`: `ptr <= sel`, `cnt <= 0`. The `ptr` source had no request, so its turn is forfeited.
- BUSY:
  - A beat transfers when `req_i[grant_o] && m_ready_i`.
  - Requests from other sources are ignored; the grant never changes mid-packet.
  - Deasserting `req_i[grant_o]` mid-packet does not release the grant.
  - On a transfer with `last_i[grant_o] = 1`: go to IDLE, `grant_valid_o <= 0`, and apply the credit update below.
- Credit update, at end of packet, with `w = max(weight_i[grant_o], 1)`:
  - If `cnt + 1 >= w`: `ptr <= (grant_o + 1) mod S_DATA_COUNT`, `cnt <= 0`.
  - Else: `ptr <= grant_o`, `cnt <= cnt + 1`.
  - The comparison is done at WEIGHT_WIDTH+1 bits, so `cnt` never wraps.
- Weight sampling: `weight_i` is sampled only at end of packet. Changing a weight mid-turn takes effect at the next packet end.
- Pointer wrap: the pointer increments from S_DATA_COUNT-1 to 0. For non-power-of-two counts, indices ≥ S_DATA_COUNT are never produced.

## Timing
- Reset (asynchronous, `rst_in` low), all outputs and registers:
  - `state` = IDLE
  - `grant_o` = 0
  - `grant_valid_o` = 0
  - `ptr` = 0, `ptr_o` = 0
  - `cnt` = 0
- Reset asserted mid-packet: the grant drops immediately (asynchronously), with no completion of the packet.
- Grant latency: `req_i` rising in cycle N gives `grant_valid_o` = 1 in cycle N+1. The first beat can transfer in N+1.
- Packet boundary: the `last` transfer in cycle N gives `grant_valid_o` = 0 in N+1 (IDLE re-arbitration) and a new grant in N+2. This is exactly one bubble cycle per packet.
- A single-beat packet (`last` on the first beat) occupies 1 BUSY cycle plus 1 IDLE cycle.
- `m_ready_i` low in BUSY: hold grant, no state change, for any number of cycles.
- Outputs are registered only; there is no combinational path from inputs to `grant_o` or `grant_valid_o`.

## Test plan
- Reset and idle:
  - Stimulus: `rst_in` low, then high, with `req_i = 0` for 10 cycles.
  - Required: `grant_valid_o = 0`, `grant_o = 0`, `ptr_o = 0` throughout.
- Equal-weight round-robin:
  - Stimulus: S_DATA_COUNT = 3, all weights 1, `req_i = 3'b111` continuously, 2-beat packets, `m_ready_i = 1`.
  - Required: grant sequence 0,1,2,0,1,2. Each grant lasts 2 cycles, followed by one `grant_valid_o = 0` cycle.
- Weighted:
  - Stimulus: weights {2,1,3} for sources {0,1,2}, all requesting, 1-beat packets.
  - Required: grant sequence 0,0,1,2,2,2,0,0, …
- Packet lock and backpressure:
  - Stimulus: source 1 granted, 4-beat packet, `m_ready_i` low for 5 cycles after beat 2, source 0 requesting throughout.
  - Required: `grant_o` stays 1 until beat 4 transfers. `grant_valid_o` falls exactly 1 cycle after that `last`.
- Turn forfeit:
  - Stimulus: `ptr_o = 1` with `cnt = 0`, weight[1] = 3, `req_i = 3'b101`.
  - Required: grant goes to 2, `ptr_o = 2`, and `cnt` is cleared.
  - Required: with weight[2] = 1, after the packet ends `ptr_o = 0`.
- Async reset mid-packet:
  - Stimulus: assert `rst_in` low in the middle of a BUSY packet.
  - Required: `grant_valid_o` = 0 in the same cycle, before the next `clk_i` edge.
  - Required: after release, the first grant goes to the lowest-index requester.
